// File: rtl/minterm_extractor_pkg.sv
// Shared definitions for the minterm extractor.
//   state_e   : controller states
//   rows()    : number of truth-table rows for n inputs
//   last_row(): index of the final row for n inputs
package minterm_extractor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

  function automatic int last_row(input int n);
    return rows(n) - 1;
  endfunction

  localparam int DEFAULT_N_VARS = 3;
  localparam int LAST_ROW       = last_row(DEFAULT_N_VARS);

endpackage

// File: rtl/minterm_extractor_row_scan_counter.sv
// Row index register plus settle down-counter for the truth-table sweep.
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_clr           : row <= 0, reload settle counter
//   i_inc           : row <= row+1 (saturates at last row), reload settle counter
//   i_settle_en     : count the settle timer down toward zero
//   o_row           : current row index
//   o_is_last       : row is the final row
//   o_settle_done   : settle timer at terminal count
module row_scan_counter
  import minterm_extractor_pkg::*;
#(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              i_settle_en,
  output logic [N_VARS-1:0] o_row,
  output logic              o_is_last,
  output logic              o_settle_done
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [N_VARS-1:0] ROW_LAST    = N_VARS'(last_row(N_VARS));

  logic [N_VARS-1:0] r_row;
  logic [SW-1:0]     r_settle;
  logic              w_is_last;

  assign w_is_last = (r_row == ROW_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row    <= '0;
      r_settle <= '0;
    end else if (i_clr) begin
      r_row    <= '0;
      r_settle <= SETTLE_LOAD;
    end else if (i_inc) begin
      // Saturate so the index can never wrap back to row 0.
      if (!w_is_last) r_row <= r_row + 1'b1;
      r_settle <= SETTLE_LOAD;
    end else if (i_settle_en && (r_settle != '0)) begin
      r_settle <= r_settle - 1'b1;
    end
  end

  assign o_row         = r_row;
  assign o_is_last     = w_is_last;
  assign o_settle_done = (r_settle == '0);

endmodule

// File: rtl/minterm_extractor.sv
// Sequential truth-table reader: sweeps all input combinations of an external
// combinational block, samples its output and streams back the indices of the
// reportable rows (minterms by default).
// Build option: MINTERM_EXTRACTOR_MAXTERM_EN reports rows where f_in=0
// (maxterms); table_out always holds the true function.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a sweep (IDLE only)
//   busy                : sweep in progress
//   vars_out            : function inputs (row index)
//   f_in                : function output under test
//   m_valid/m_ready     : index stream handshake
//   m_index             : reported row index
//   done                : one-cycle end-of-sweep pulse
//   count               : number of reported rows in last sweep
//   table_out           : captured truth table, bit i = f(i)
//
// state  | meaning
// IDLE   | waiting for start
// DRIVE  | vars_out = row, waiting SETTLE cycles
// SAMPLE | capture f_in into table_out[row]
// EMIT   | offer row index, wait for handshake
// DONE   | one-cycle done pulse, back to IDLE
module minterm_extractor
  import minterm_extractor_pkg::*;
#(
  parameter int N_VARS = 3,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic [N_VARS-1:0]        vars_out,
  input  logic                     f_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_VARS-1:0]        m_index,
  output logic                     done,
  output logic [N_VARS:0]          count,
  output logic [rows(N_VARS)-1:0]  table_out
);

  localparam int ROWS = rows(N_VARS);

  state_e            r_state;
  logic              r_busy;
  logic              r_m_valid;
  logic [N_VARS-1:0] r_m_index;
  logic              r_done;
  logic [N_VARS:0]   r_count;
  logic [ROWS-1:0]   r_table;

  logic [N_VARS-1:0] w_row;
  logic              w_is_last;
  logic              w_settle_done;
  logic              w_report;
  logic              w_handshake;
  logic              w_clr;
  logic              w_inc;
  logic              w_settle_en;

`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
  assign w_report = ~f_in;
`else
  assign w_report = f_in;
`endif

  assign w_handshake = (r_state == EMIT) && r_m_valid && m_ready;
  assign w_clr       = (r_state == IDLE) && start;
  assign w_inc       = ((r_state == SAMPLE) && !w_report && !w_is_last) ||
                       (w_handshake && !w_is_last);
  assign w_settle_en = (r_state == DRIVE);

  row_scan_counter #(
    .N_VARS (N_VARS),
    .SETTLE (SETTLE)
  ) u_row_scan_counter (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clr         (w_clr),
    .i_inc         (w_inc),
    .i_settle_en   (w_settle_en),
    .o_row         (w_row),
    .o_is_last     (w_is_last),
    .o_settle_done (w_settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_index <= '0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_table   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= DRIVE;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_table <= '0;
          end
        end
        DRIVE: begin
          if (w_settle_done) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_table[w_row] <= f_in;
          if (w_report) begin
            r_state   <= EMIT;
            r_m_valid <= 1'b1;
            r_m_index <= w_row;
          end else if (w_is_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DRIVE;
          end
        end
        EMIT: begin
          if (w_handshake) begin
            r_count   <= r_count + 1'b1;
            r_m_valid <= 1'b0;
            if (w_is_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DRIVE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign vars_out  = w_row;
  assign m_valid   = r_m_valid;
  assign m_index   = r_m_index;
  assign done      = r_done;
  assign count     = r_count;
  assign table_out = r_table;

endmodule

// File: tb/tb_minterm_extractor.sv
// Self-checking bench for minterm_extractor (N_VARS=3, SETTLE=1). The function
// under test is a truth table held in the bench; expected index streams,
// counts and sweep lengths are derived from that table directly.
module tb_minterm_extractor;

  localparam int NV   = 3;
  localparam int SET  = 1;
  localparam int ROWS = 8;
`ifdef MINTERM_EXTRACTOR_MAXTERM_EN
  localparam bit REP = 1'b0;
`else
  localparam bit REP = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic [NV-1:0]   vars_out;
  logic            f_in;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [NV-1:0]   m_index;
  logic            done;
  logic [NV:0]     count;
  logic [ROWS-1:0] table_out;
  logic [ROWS-1:0] tt = '0;

  int n_chk = 0;
  int n_fail = 0;

  assign f_in = tt[vars_out];

  always #5 clk = ~clk;

  minterm_extractor #(.N_VARS(NV), .SETTLE(SET)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .vars_out  (vars_out),
    .f_in      (f_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_index   (m_index),
    .done      (done),
    .count     (count),
    .table_out (table_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: m_ready always 1; 1: random m_ready; 2: hold off index 3 for 5 cycles
  // noise: random start pulses while the sweep runs
  // abort3: reset the DUT while index 3 is being offered
  task automatic run_sweep(input logic [ROWS-1:0] t, input int mode,
                           input bit noise, input bit abort3);
    int exp_q[$];
    int got_q[$];
    int done_at;
    int done_cnt;
    int stall;
    bit prev_wait;
    logic [NV-1:0] prev_idx;
    tt = t;
    for (int i = 0; i < ROWS; i++)
      if (t[i] == REP) exp_q.push_back(i);
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    done_at = -1;
    done_cnt = 0;
    stall = 0;
    prev_wait = 1'b0;
    prev_idx = '0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_start", busy, 1);
      if (prev_wait) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_index", m_index, prev_idx);
        chk("hold_vars", vars_out, prev_idx);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk("busy_at_done", busy, 0);
        end
      end
      start = (noise && done_at < 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      case (mode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: begin
          if (m_valid && m_index == 3 && stall < 5) begin
            m_ready = 1'b0;
            stall++;
          end else m_ready = 1'b1;
        end
        default: m_ready = 1'b1;
      endcase
      if (abort3 && m_valid && m_index == 3) begin
        m_ready = 1'b0;
        stall++;
        if (stall == 3) begin
          rst_n = 1'b0;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_vars", vars_out, 0);
          chk("rst_valid", m_valid, 0);
          chk("rst_index", m_index, 0);
          chk("rst_done", done, 0);
          chk("rst_count", count, 0);
          chk("rst_table", table_out, 0);
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
          end
          rst_n = 1'b1;
          m_ready = 1'b1;
          return;
        end
      end
      if (m_valid && m_ready) got_q.push_back(int'(m_index));
      prev_wait = m_valid && !m_ready;
      prev_idx = m_index;
      if (done_at > 0 && k >= done_at + 3) break;
    end
    start = 1'b0;
    m_ready = 1'b1;
    if (done_at < 0) begin
      chk("timeout_no_done", 0, 1);
    end else begin
      if (mode == 0)
        chk("sweep_len", done_at - 1, ROWS * (SET + 1) + exp_q.size());
      chk("done_pulses", done_cnt, 1);
      chk("busy_idle", busy, 0);
      chk("count", count, exp_q.size());
      chk("table_out", table_out, t);
      chk("n_indices", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk("index", got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_vars", vars_out, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_index", m_index, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    chk("reset_table", table_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(8'b10011010, 0, 1'b0, 1'b0);
    run_sweep(8'h00, 0, 1'b0, 1'b0);
    run_sweep(8'hFF, 0, 1'b0, 1'b0);
    run_sweep(8'b10011010, 2, 1'b0, 1'b0);
    run_sweep(8'b10011010, 0, 1'b1, 1'b0);
    run_sweep(8'b10011010, 0, 1'b0, 1'b1);
    run_sweep(8'b10011010, 0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++)
      run_sweep(8'($urandom_range(0, 255)), (r % 2 == 0) ? 1 : 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
